// File: rtl/uart_frame_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_parser_pkg
// Brief   : Shared constants, error codes and FSM encoding for the UART
//           matrix-frame parser.
// Revision: 1.0 - initial release
// ============================================================================
package uart_frame_parser_pkg;

  // Start-of-frame marker; only recognised while idle.
  localparam logic [7:0] C_HDR_BYTE    = 8'hAA;

  // err_code values.
  localparam logic [1:0] C_ERR_NONE    = 2'd0;
  localparam logic [1:0] C_ERR_DIM     = 2'd1;
  localparam logic [1:0] C_ERR_CHK     = 2'd2;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'd3;

  // Default largest row/column count accepted.
  localparam int C_MAX_DIM_DEF = 5;

  // Parser states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ROWS = 3'd2,
    ST_COLS = 3'd3,
    ST_DATA = 3'd4,
    ST_CHK  = 3'd5
  } state_e;

  // A dimension byte is legal when it lies in 1..max_dim.
  function automatic logic dim_ok(input logic [7:0] v, input logic [7:0] max_dim);
    return (v != 8'd0) && (v <= max_dim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module  : byte_timeout_timer
// Brief   : Inter-byte watchdog. Counts clk cycles while enabled; expired is
//           a combinational flag raised on the edge where the count would
//           reach TIMEOUT_CYC, suppressed whenever clear is high.
// Revision: 1.0 - initial release
// ============================================================================
module byte_timeout_timer #(
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A fresh byte always wins over the terminal count.
  assign expired = enable && !clear && (cnt_q == C_LAST);

  // Next count: restart on a byte, when disabled, or once the timer fires.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || !enable || expired) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_parser
// Brief   : Parses AA/CMD/ROWS/COLS/elements/CHK frames from a UART byte
//           stream, streams matrix element writes, and reports good frames,
//           dimension/checksum errors and inter-byte timeouts.
// Revision: 1.0 - initial release
// ============================================================================
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int MAX_DIM     = C_MAX_DIM_DEF,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] frame_cmd,
  output logic [2:0] frame_rows,
  output logic [2:0] frame_cols,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [7:0] C_MAX = 8'(MAX_DIM);

  state_e     state_q, state_d;
  logic [7:0] xor_q, xor_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] rows_q, rows_d;
  logic [2:0] cols_q, cols_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] last_q, last_d;
  logic       wr_en_q, wr_en_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] frame_cmd_q, frame_cmd_d;
  logic [2:0] frame_rows_q, frame_rows_d;
  logic [2:0] frame_cols_q, frame_cols_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;
  logic [1:0] err_code_q, err_code_d;

  logic       w_expired;
  logic [5:0] w_prod;

  // Element count of the frame whose COLS byte is arriving now.
  assign w_prod = {3'd0, rows_q[2:0]} * {3'd0, rx_data[2:0]};

  byte_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_done),
    .enable  (state_q != ST_IDLE),
    .expired (w_expired)
  );

  // Next-state and output decode; every step is triggered by a byte, except timeout.
  always_comb begin
    state_d      = state_q;
    xor_d        = xor_q;
    cmd_d        = cmd_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_cmd_d  = frame_cmd_q;
    frame_rows_d = frame_rows_q;
    frame_cols_d = frame_cols_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;

    if (w_expired) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      err_code_d  = C_ERR_TIMEOUT;
    end else if (rx_done) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == C_HDR_BYTE) begin
            state_d = ST_CMD;
            xor_d   = 8'd0;
          end
        end
        ST_CMD: begin
          cmd_d   = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = ST_ROWS;
        end
        ST_ROWS: begin
          rows_d  = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = ST_COLS;
        end
        ST_COLS: begin
          xor_d = xor_q ^ rx_data;
          if (dim_ok(rows_q, C_MAX) && dim_ok(rx_data, C_MAX)) begin
            cols_d  = rx_data[2:0];
            cnt_d   = 6'd0;
            last_d  = w_prod - 6'd1;
            state_d = ST_DATA;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = C_ERR_DIM;
            state_d     = ST_IDLE;
          end
        end
        ST_DATA: begin
          xor_d     = xor_q ^ rx_data;
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[4:0];
          wr_data_d = rx_data;
          cnt_d     = cnt_q + 6'd1;
          if (cnt_q == last_q) begin
            state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          if (rx_data == xor_q) begin
            frame_done_d = 1'b1;
            frame_cmd_d  = cmd_q;
            frame_rows_d = rows_q[2:0];
            frame_cols_d = cols_q;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = C_ERR_CHK;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset abandons any partial frame silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      xor_q        <= 8'd0;
      cmd_q        <= 8'd0;
      rows_q       <= 8'd0;
      cols_q       <= 3'd0;
      cnt_q        <= 6'd0;
      last_q       <= 6'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 5'd0;
      wr_data_q    <= 8'd0;
      frame_cmd_q  <= 8'd0;
      frame_rows_q <= 3'd0;
      frame_cols_q <= 3'd0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= C_ERR_NONE;
    end else begin
      state_q      <= state_d;
      xor_q        <= xor_d;
      cmd_q        <= cmd_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_cmd_q  <= frame_cmd_d;
      frame_rows_q <= frame_rows_d;
      frame_cols_q <= frame_cols_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_cmd  = frame_cmd_q;
  assign frame_rows = frame_rows_q;
  assign frame_cols = frame_cols_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
